// File: rtl/axi_wr_arbiter_if.sv
// rtl/axi_wr_arbiter_if.sv - bundle of the two-master write ports and the shared slave write path
//
// Purpose: groups every handshake/bus signal of axi_wr_arbiter.
//   m_*   : per-master AW/W/B channels, master i packed at [i*width +: width]
//   s_*   : single shared slave AW/W/B channel
//   grant : one-hot owner of the slave path, 2'b00 when idle
// Modports:
//   slave  : arbiter view (consumes master requests, drives the slave channel)
//   master : environment view (drives master requests and slave responses)
interface axi_wr_arbiter_if #(
    parameter int addr_width   = 4,
    parameter int len          = 4,
    parameter int burst_length = 2,
    parameter int data_width   = 32,
    parameter int resp         = 2
);
    logic [2*addr_width-1:0]   m_awaddr;
    logic [2*len-1:0]          m_awlen;
    logic [2*burst_length-1:0] m_awburst;
    logic [1:0]                m_awvalid;
    logic [1:0]                m_awready;
    logic [2*data_width-1:0]   m_wdata;
    logic [1:0]                m_wvalid;
    logic [1:0]                m_wready;
    logic [2*resp-1:0]         m_bresp;
    logic [1:0]                m_bvalid;
    logic [1:0]                m_bready;

    logic [addr_width-1:0]     s_awaddr;
    logic [len-1:0]            s_awlen;
    logic [burst_length-1:0]   s_awburst;
    logic                      s_awvalid;
    logic                      s_awready;
    logic [data_width-1:0]     s_wdata;
    logic                      s_wlast;
    logic                      s_wvalid;
    logic                      s_wready;
    logic [resp-1:0]           s_bresp;
    logic                      s_bvalid;
    logic                      s_bready;

    logic [1:0]                grant;

    modport slave (
        input  m_awaddr, m_awlen, m_awburst, m_awvalid, m_wdata, m_wvalid, m_bready,
        output m_awready, m_wready, m_bresp, m_bvalid,
        output s_awaddr, s_awlen, s_awburst, s_awvalid, s_wdata, s_wlast, s_wvalid, s_bready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        output grant
    );

    modport master (
        output m_awaddr, m_awlen, m_awburst, m_awvalid, m_wdata, m_wvalid, m_bready,
        input  m_awready, m_wready, m_bresp, m_bvalid,
        input  s_awaddr, s_awlen, s_awburst, s_awvalid, s_wdata, s_wlast, s_wvalid, s_bready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        input  grant
    );
endinterface

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - two-master round-robin arbiter for a single write slave
//
// Purpose: serialises whole write transactions (AW, W burst, B) from two
// masters onto one slave path, one transaction in flight at a time.
// Ports:
//   aclk   : clock, rising edge
//   areset : synchronous active-high reset
//   bus    : axi_wr_arbiter_if.slave carrying the master channels, the
//            slave channel and the registered one-hot grant
module axi_wr_arbiter #(
    parameter int addr_width   = 4,
    parameter int len          = 4,
    parameter int burst_length = 2,
    parameter int data_width   = 32,
    parameter int resp         = 2
) (
    input  logic                 aclk,
    input  logic                 areset,
    axi_wr_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t           state;
    logic [1:0]       grant_q;
    logic             last_g;     // index of the master served most recently
    logic [len-1:0]   beat_cnt;
    logic [len-1:0]   len_q;

    // Grant is one-hot, so its upper bit is the owner index.
    logic gi;
    assign gi = grant_q[1];

    // Granted master's request fields.
    logic [addr_width-1:0]   sel_awaddr;
    logic [len-1:0]          sel_awlen;
    logic [burst_length-1:0] sel_awburst;
    logic                    sel_awvalid;
    logic [data_width-1:0]   sel_wdata;
    logic                    sel_wvalid;
    logic                    sel_bready;

    assign sel_awaddr  = gi ? bus.m_awaddr[addr_width +: addr_width]     : bus.m_awaddr[0 +: addr_width];
    assign sel_awlen   = gi ? bus.m_awlen[len +: len]                    : bus.m_awlen[0 +: len];
    assign sel_awburst = gi ? bus.m_awburst[burst_length +: burst_length] : bus.m_awburst[0 +: burst_length];
    assign sel_awvalid = gi ? bus.m_awvalid[1] : bus.m_awvalid[0];
    assign sel_wdata   = gi ? bus.m_wdata[data_width +: data_width]      : bus.m_wdata[0 +: data_width];
    assign sel_wvalid  = gi ? bus.m_wvalid[1]  : bus.m_wvalid[0];
    assign sel_bready  = gi ? bus.m_bready[1]  : bus.m_bready[0];

    logic aw_act, w_act, b_act;
    assign aw_act = (state == ADDR);
    assign w_act  = (state == DATA);
    assign b_act  = (state == RESP);

    logic wlast;
    assign wlast = w_act && (beat_cnt == len_q);

    // Round-robin pick: on a tie the master not served last wins.
    logic [1:0] pick;
    always_comb begin
        pick = 2'b00;
        if (&bus.m_awvalid)
            pick = last_g ? 2'b01 : 2'b10;
        else if (bus.m_awvalid[0])
            pick = 2'b01;
        else if (bus.m_awvalid[1])
            pick = 2'b10;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= IDLE;
            grant_q  <= 2'b00;
            last_g   <= 1'b1;
            beat_cnt <= '0;
            len_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.m_awvalid) begin
                        grant_q <= pick;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (sel_awvalid && bus.s_awready) begin
                        len_q    <= sel_awlen;
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (sel_wvalid && bus.s_wready) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (wlast)
                            state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.s_bvalid && sel_bready) begin
                        last_g  <= gi;
                        grant_q <= 2'b00;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Routing is purely combinational from registered state/grant; every
    // channel outside its active state is forced to zero.
    always_comb begin
        bus.s_awaddr  = aw_act ? sel_awaddr  : '0;
        bus.s_awlen   = aw_act ? sel_awlen   : '0;
        bus.s_awburst = aw_act ? sel_awburst : '0;
        bus.s_awvalid = aw_act && sel_awvalid;
        bus.m_awready = aw_act ? (grant_q & {2{bus.s_awready}}) : 2'b00;

        bus.s_wdata   = w_act ? sel_wdata : '0;
        bus.s_wvalid  = w_act && sel_wvalid;
        bus.s_wlast   = wlast;
        bus.m_wready  = w_act ? (grant_q & {2{bus.s_wready}}) : 2'b00;

        bus.s_bready  = b_act && sel_bready;
        bus.m_bvalid  = b_act ? (grant_q & {2{bus.s_bvalid}}) : 2'b00;
        bus.m_bresp   = '0;
        if (b_act) begin
            if (gi)
                bus.m_bresp[resp +: resp] = bus.s_bresp;
            else
                bus.m_bresp[0 +: resp] = bus.s_bresp;
        end

        bus.grant     = grant_q;
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - directed self-checking bench for axi_wr_arbiter
module tb_axi_wr_arbiter;

    logic aclk;
    logic areset;

    axi_wr_arbiter_if bus ();

    axi_wr_arbiter dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction for master g; the requesting awvalid bits
    // must already be set. rearm keeps g's awvalid high afterwards.
    task automatic txn(input int g, input int nbeats, input logic [3:0] exp_addr,
                       input logic [1:0] exp_burst, input int stall, input bit rearm);
        logic [1:0]  gh;
        logic [31:0] d;
        logic [1:0]  br;
        gh = 2'(1 << g);
        tick();
        chk("grant", 64'(bus.grant), 64'(gh));
        bus.s_awready = 1'b1;
        #1;
        chk("s_awvalid", 64'(bus.s_awvalid), 64'd1);
        chk("s_awaddr", 64'(bus.s_awaddr), 64'(exp_addr));
        chk("s_awlen", 64'(bus.s_awlen), 64'(nbeats - 1));
        chk("s_awburst", 64'(bus.s_awburst), 64'(exp_burst));
        chk("m_awready_addr", 64'(bus.m_awready), 64'(gh));
        tick();
        if (!rearm) bus.m_awvalid[g] = 1'b0;
        bus.s_awready = 1'b0;
        #1;
        chk("s_awvalid_off", 64'(bus.s_awvalid), 64'd0);
        for (int s = 0; s < stall; s++) begin
            bus.m_wdata[g*32 +: 32] = 32'(256 * g + 5);
            bus.m_wvalid[g] = 1'b1;
            bus.s_wready    = 1'b0;
            #1;
            chk("m_wready_stall", 64'(bus.m_wready), 64'd0);
            chk("s_wlast_stall", 64'(bus.s_wlast), 64'(nbeats == 1));
            tick();
        end
        for (int k = 0; k < nbeats; k++) begin
            d = 32'(256 * g + 5 + k);
            bus.m_wdata[g*32 +: 32] = d;
            bus.m_wvalid[g] = 1'b1;
            bus.s_wready    = 1'b1;
            #1;
            chk("s_wdata", 64'(bus.s_wdata), 64'(d));
            chk("s_wlast", 64'(bus.s_wlast), 64'(k == nbeats - 1));
            chk("m_wready", 64'(bus.m_wready), 64'(gh));
            chk("m_awready_data", 64'(bus.m_awready), 64'd0);
            tick();
        end
        bus.m_wvalid[g] = 1'b0;
        bus.s_wready    = 1'b0;
        br = 2'(g + 1);
        bus.s_bresp  = br;
        bus.s_bvalid = 1'b1;
        bus.m_bready = 2'b11;
        #1;
        chk("s_wvalid_resp", 64'(bus.s_wvalid), 64'd0);
        chk("m_bvalid", 64'(bus.m_bvalid), 64'(gh));
        chk("m_bresp", 64'(bus.m_bresp), 64'(br) << (2 * g));
        chk("s_bready", 64'(bus.s_bready), 64'd1);
        tick();
        bus.s_bvalid = 1'b0;
        bus.s_bresp  = 2'b00;
        bus.m_bready = 2'b00;
        #1;
        chk("grant_done", 64'(bus.grant), 64'd0);
        chk("m_bvalid_done", 64'(bus.m_bvalid), 64'd0);
    endtask

    initial begin
        areset        = 1'b1;
        bus.m_awaddr  = {4'd9, 4'd1};
        bus.m_awlen   = {4'd1, 4'd3};
        bus.m_awburst = {2'd2, 2'd1};
        bus.m_awvalid = 2'b00;
        bus.m_wdata   = '0;
        bus.m_wvalid  = 2'b00;
        bus.m_bready  = 2'b00;
        bus.s_awready = 1'b0;
        bus.s_wready  = 1'b0;
        bus.s_bresp   = 2'b00;
        bus.s_bvalid  = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        #1;
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_s_awvalid", 64'(bus.s_awvalid), 64'd0);
        chk("rst_s_wvalid", 64'(bus.s_wvalid), 64'd0);
        chk("rst_s_bready", 64'(bus.s_bready), 64'd0);

        // Single master m0: addr 1, 4 beats, incr.
        bus.m_awvalid = 2'b01;
        #1;
        chk("idle_m_awready", 64'(bus.m_awready), 64'd0);
        txn(0, 4, 4'd1, 2'd1, 0, 1'b0);

        // Simultaneous requests after reset: m0 first, then m1, then alternate.
        areset = 1'b1;
        tick();
        areset = 1'b0;
        bus.m_awvalid = 2'b11;
        txn(0, 4, 4'd1, 2'd1, 0, 1'b1);
        txn(1, 2, 4'd9, 2'd2, 0, 1'b1);
        txn(0, 4, 4'd1, 2'd1, 0, 1'b1);
        txn(1, 2, 4'd9, 2'd2, 0, 1'b0);
        bus.m_awvalid = 2'b00;
        tick();
        #1;
        chk("idle_grant", 64'(bus.grant), 64'd0);

        // awlen=0 single beat with a 3-cycle W stall.
        bus.m_awlen[3:0] = 4'd0;
        bus.m_awvalid = 2'b01;
        txn(0, 1, 4'd1, 2'd1, 3, 1'b0);
        bus.m_awlen[3:0] = 4'd3;

        // Reset during DATA after 2 of 4 beats.
        bus.m_awvalid = 2'b01;
        tick();
        chk("abort_grant", 64'(bus.grant), 64'd1);
        bus.s_awready = 1'b1;
        tick();
        bus.m_awvalid = 2'b00;
        bus.s_awready = 1'b0;
        bus.m_wvalid  = 2'b01;
        bus.s_wready  = 1'b1;
        tick();
        tick();
        areset = 1'b1;
        bus.s_bvalid = 1'b1;
        bus.m_bready = 2'b01;
        tick();
        areset = 1'b0;
        #1;
        chk("abort_grant_clr", 64'(bus.grant), 64'd0);
        chk("abort_s_wvalid", 64'(bus.s_wvalid), 64'd0);
        chk("abort_m_wready", 64'(bus.m_wready), 64'd0);
        chk("abort_s_wlast", 64'(bus.s_wlast), 64'd0);
        chk("abort_m_bvalid", 64'(bus.m_bvalid), 64'd0);
        chk("abort_s_bready", 64'(bus.s_bready), 64'd0);
        bus.m_wvalid = 2'b00;
        bus.s_wready = 1'b0;
        bus.s_bvalid = 1'b0;
        bus.m_bready = 2'b00;
        bus.m_awvalid = 2'b10;
        txn(1, 2, 4'd9, 2'd2, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
